// File: rtl/booth_seq_mul_if.sv
// Operand/product handshake bundle for booth_seq_mul.
// The master side issues operands and consumes products.
interface booth_seq_mul_if #(
   parameter int WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               is_signed;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] p;

   modport master (
      output in_valid, a, b, is_signed, out_ready,
      input  in_ready, out_valid, p
   );

   modport slave (
      input  in_valid, a, b, is_signed, out_ready,
      output in_ready, out_valid, p
   );
endinterface

// File: rtl/booth_seq_mul.sv
// Iterative radix-2 Booth multiplier: one add/sub-and-shift step per clock,
// signed or unsigned operands selected per transaction, valid/ready on both sides.
module booth_seq_mul #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic           clk,
   input  logic           rst_n,
   booth_seq_mul_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nx;
   logic [WIDTH+1:0]   acc, m, sum;
   logic [WIDTH:0]     q;
   logic               q_1;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] p_r;
   logic [WIDTH+1:0]   acc_nx;
   logic [WIDTH:0]     q_nx;
   logic               q1_nx;
   logic               last_step;

   assign last_step = (cnt == CNT_W'(WIDTH));

   always_comb begin
      sum = acc;
      unique case ({q[0], q_1})
         2'b10:   sum = acc - m;
         2'b01:   sum = acc + m;
         default: sum = acc;
      endcase
   end

   // Arithmetic right shift of {A,Q,q-1} after the Booth add/sub.
   assign acc_nx = {sum[WIDTH+1], sum[WIDTH+1:1]};
   assign q_nx   = {sum[0], q[WIDTH:1]};
   assign q1_nx  = q[0];

   always_comb begin
      state_nx      = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nx = RUN;
         end
         RUN: begin
            if (last_step) state_nx = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         m   <= '0;
         q   <= '0;
         q_1 <= 1'b0;
         cnt <= '0;
         p_r <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  acc <= '0;
                  q_1 <= 1'b0;
                  cnt <= '0;
                  q   <= {bus.is_signed & bus.a[WIDTH-1], bus.a};
                  m   <= {{2{bus.is_signed & bus.b[WIDTH-1]}}, bus.b};
               end
            end
            RUN: begin
               acc <= acc_nx;
               q   <= q_nx;
               q_1 <= q1_nx;
               cnt <= cnt + CNT_W'(1);
               // Product captured from the final step so p never shows partial sums.
               if (last_step) p_r <= {acc_nx[WIDTH-2:0], q_nx};
            end
            default: ;
         endcase
      end
   end

   assign bus.p = p_r;
endmodule

// File: doc/booth_seq_mul.md
Name: booth_seq_mul

Overview:
Iterative radix-2 Booth multiplier, parametrised in operand width, one Booth add/sub-and-shift step per clock. Supports signed (two's complement) and unsigned operands, selected per transaction. Valid/ready handshakes on input and output. Successor to the combinational unrolled 8-bit Booth array; trades latency for area on wider datapaths.

Parameters:
WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+2), iteration counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands presented.
in_ready  output  1  block can accept operands.
a  input  WIDTH  multiplier operand.
b  input  WIDTH  multiplicand operand.
is_signed  input  1  1 = two's complement operands, 0 = unsigned; sampled with a/b.
out_valid  output  1  product available.
out_ready  input  1  consumer accepts product.
p  output  2*WIDTH  product a*b.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, in_ready=1, out_valid=0, p=0, counter=0, internal A/Q/M/q-1 registers=0. Reset mid-operation aborts; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge k: latch M = b extended to WIDTH+2 bits, Q = a extended to WIDTH+1 bits (sign-extend if is_signed, else zero-extend), A=0, q-1=0, counter=0 -> RUN.
- RUN: in_ready=0, out_valid=0. Each edge one step on (Q[0], q-1): 00/11 none, 10 A=A-M, 01 A=A+M; then arithmetic right shift of {A,Q,q-1} by one (A MSB replicated). A is WIDTH+2 bits so -2^(WIDTH-1) multiplicand and unsigned max never overflow. counter increments; after WIDTH+1 steps -> DONE.
- Latency fixed: accept at edge k, out_valid=1 after edge k+WIDTH+1, independent of operand values and is_signed.
- DONE: out_valid=1, p = low 2*WIDTH bits of {A,Q} (exact product for both modes). p and out_valid held stable until out_ready=1; on out_valid&&out_ready at an edge -> IDLE (out_valid=0 next cycle, p holds last value). No accept in the same cycle as output handoff; minimum issue interval WIDTH+3 cycles.
- in_valid asserted while in_ready=0 is ignored; a/b/is_signed need only be stable on the accepting edge.
- Arithmetic: add/sub are WIDTH+2-bit two's complement, carry-out discarded. is_signed affects only operand extension.
- No X on any output after reset; p does not change in RUN.

Test Plan:
- Reset then WIDTH=8, is_signed=1, a=-16, b=-16 -> out_valid exactly 9 cycles after accept, p=16'd256; in_ready low during RUN.
- Signed sweep: (-107,32)->-3424, (7,0)->0, (127,-128)->-16256, (-128,-128)->16384, (1,1)->1; each p matches a*b in 16-bit two's complement.
- Unsigned: is_signed=0, a=8'hFF, b=8'hFF -> p=16'hFE01 (65025); a=8'h80, b=8'h02 -> p=16'h0100.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> p and out_valid stable; in_valid pulses during that window are not accepted; out_ready=1 -> IDLE next cycle, then next operands accepted.
- Reset mid-RUN: assert rst_n=0 at step 4, release -> out_valid=0, in_ready=1 immediately, p=0; fresh transaction (3,5) -> 15 with full latency.
- Parameter sweep WIDTH=4,16,32: random signed/unsigned operands vs reference model, latency WIDTH+1 each; WIDTH=16 corner -32768*-32768 -> 32'h40000000.
